// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the 65HE06 core stages.
// Holds the memory-access FSM encoding, access-size codes and the
// register indices the execute stage also relies on.
package core_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;
    localparam logic ACC_BYTE = 1'b0;
    localparam logic ACC_WORD = 1'b1;
    localparam logic [2:0] R_SF = 3'd2;
    localparam logic [2:0] R_PC = 3'd3;
endpackage

// File: rtl/mem_unit_if.sv
// mem_unit_if: signal bundle around the memory-access stage.
// Ports: req_* (execute-stage request), bus_* (8-bit external bus),
// ld_* / st_done (writeback results) and busy.
// master = execute stage plus external bus; slave = mem_unit.
interface mem_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_word;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic [2:0]  req_d_idx;
    logic        bus_en;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ready;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic [2:0]  ld_d_idx;
    logic        st_done;
    logic        busy;
    modport master (
        output req_valid, req_write, req_word, req_addr, req_data, req_d_idx,
        output bus_rdata, bus_ready,
        input  req_ready, bus_en, bus_we, bus_addr, bus_wdata,
        input  ld_valid, ld_data, ld_d_idx, st_done, busy
    );
    modport slave (
        input  req_valid, req_write, req_word, req_addr, req_data, req_d_idx,
        input  bus_rdata, bus_ready,
        output req_ready, bus_en, bus_we, bus_addr, bus_wdata,
        output ld_valid, ld_data, ld_d_idx, st_done, busy
    );
endinterface

// File: rtl/mem_unit.sv
// mem_unit: memory-access stage; byte/word transfers over an 8-bit bus.
// Ports: clk, rst (sync, active-high), mu (mem_unit_if.slave: request,
// bus and writeback signals). Words are two little-endian byte cycles.
module mem_unit
    import core_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    mem_unit_if.slave mu
);
    state_t      state;
    state_t      state_nx;
    logic        write;
    logic        word;
    logic [15:0] addr;
    logic [15:0] data;
    logic [2:0]  d_idx;
    logic [7:0]  lo;
    logic        fire;
    logic        done;

    assign mu.req_ready = state == IDLE;
    assign mu.busy      = state != IDLE;

    always_comb begin
        fire     = mu.bus_en & mu.bus_ready;
        done     = fire & (state == HI | word == ACC_BYTE);
        state_nx = state == IDLE ? (mu.req_valid ? LO : IDLE) :
                   done          ? IDLE :
                   fire          ? HI : state;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write        <= 1'b0;
            word         <= ACC_BYTE;
            addr         <= '0;
            data         <= '0;
            d_idx        <= '0;
            lo           <= '0;
            mu.bus_en    <= 1'b0;
            mu.bus_we    <= 1'b0;
            mu.bus_addr  <= '0;
            mu.bus_wdata <= '0;
            mu.ld_valid  <= 1'b0;
            mu.st_done   <= 1'b0;
            mu.ld_data   <= '0;
            mu.ld_d_idx  <= '0;
        end else begin
            mu.ld_valid <= done & ~write;
            mu.st_done  <= done & write;
            if (state == IDLE && mu.req_valid) begin
                write        <= mu.req_write;
                word         <= mu.req_word;
                addr         <= mu.req_addr;
                data         <= mu.req_data;
                d_idx        <= mu.req_d_idx;
                mu.bus_en    <= 1'b1;
                mu.bus_we    <= mu.req_write;
                mu.bus_addr  <= mu.req_addr;
                mu.bus_wdata <= mu.req_data[7:0];
            end
            // low byte done on a word: retarget the bus at the high byte
            if (fire && state == LO && word == ACC_WORD) begin
                lo           <= mu.bus_rdata;
                mu.bus_addr  <= addr + 16'd1;
                mu.bus_wdata <= data[15:8];
            end
            if (done) begin
                mu.bus_en <= 1'b0;
                mu.bus_we <= 1'b0;
            end
            if (done && !write) begin
                mu.ld_data  <= state == HI ? {mu.bus_rdata, lo} : {8'h00, mu.bus_rdata};
                mu.ld_d_idx <= d_idx;
            end
        end
    end
endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: randomized scoreboard bench for mem_unit.
module tb_mem_unit;
    import core_pkg::*;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_t;

    typedef struct packed {
        logic        ld;
        logic [15:0] data;
        logic [2:0]  idx;
    } cpl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_unit_if bus_if ();

    mem_unit dut (
        .clk (clk),
        .rst (rst),
        .mu  (bus_if)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic [7:0] ref_mem [0:65535];
    logic [7:0] bus_mem [0:65535];
    bus_t bus_q [$];
    cpl_t cpl_q [$];
    int   wait_plan [$];
    bit   rnd_waits = 1'b0;
    int   cur_wait = -1;
    int   last_ld_cyc = -1;
    int   last_st_cyc = -1;
    bit   held = 1'b0;
    bus_t held_v;
    bus_t be;
    cpl_t ce;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // External bus model plus both scoreboard monitors, all on the falling edge.
    always @(negedge clk) begin
        if (held) begin
            check("bus_hold_en", 32'(bus_if.bus_en), 1);
            check("bus_hold_vals", 32'({bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata}), 32'(held_v));
        end
        held = 1'b0;
        if (!bus_if.bus_en) begin
            cur_wait = -1;
            bus_if.bus_ready = 1'($urandom_range(0, 1));
            bus_if.bus_rdata = 8'($urandom);
        end else begin
            if (cur_wait < 0)
                cur_wait = wait_plan.size() != 0 ? wait_plan.pop_front() :
                           rnd_waits ? int'($urandom_range(0, 2)) : 0;
            if (cur_wait > 0) begin
                cur_wait--;
                bus_if.bus_ready = 1'b0;
                bus_if.bus_rdata = 8'($urandom);
                held = 1'b1;
                held_v = {bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata};
            end else begin
                cur_wait = -1;
                bus_if.bus_ready = 1'b1;
                bus_if.bus_rdata = bus_mem[bus_if.bus_addr];
                if (bus_if.bus_we) bus_mem[bus_if.bus_addr] = bus_if.bus_wdata;
                if (bus_q.size() == 0) begin
                    check("bus_cycle_expected", 0, 1);
                end else begin
                    be = bus_q.pop_front();
                    check("bus_we", 32'(bus_if.bus_we), 32'(be.we));
                    check("bus_addr", 32'(bus_if.bus_addr), 32'(be.addr));
                    if (be.we) check("bus_wdata", 32'(bus_if.bus_wdata), 32'(be.wdata));
                end
            end
        end
        if (bus_if.ld_valid || bus_if.st_done) begin
            if (bus_if.ld_valid) last_ld_cyc = cyc;
            if (bus_if.st_done) last_st_cyc = cyc;
            if (cpl_q.size() == 0) begin
                check("completion_expected", 0, 1);
            end else begin
                ce = cpl_q.pop_front();
                check("cpl_is_load", 32'(bus_if.ld_valid), 32'(ce.ld));
                check("cpl_is_store", 32'(bus_if.st_done), 32'(!ce.ld));
                if (ce.ld) begin
                    check("ld_data", 32'(bus_if.ld_data), 32'(ce.data));
                    check("ld_d_idx", 32'(bus_if.ld_d_idx), 32'(ce.idx));
                end
            end
        end
    end

    // Reference model: a flat byte memory updated in request order.
    task automatic model(input logic w, input logic wd, input logic [15:0] a,
                         input logic [15:0] d, input logic [2:0] idx);
        logic [15:0] a1;
        logic [7:0]  lo;
        logic [7:0]  hi;
        a1 = a + 16'd1;
        if (w) begin
            ref_mem[a] = d[7:0];
            bus_q.push_back('{we: 1'b1, addr: a, wdata: d[7:0]});
            if (wd) begin
                ref_mem[a1] = d[15:8];
                bus_q.push_back('{we: 1'b1, addr: a1, wdata: d[15:8]});
            end
            cpl_q.push_back('{ld: 1'b0, data: 16'h0, idx: 3'd0});
        end else begin
            lo = ref_mem[a];
            hi = wd ? ref_mem[a1] : 8'h00;
            bus_q.push_back('{we: 1'b0, addr: a, wdata: 8'h00});
            if (wd) bus_q.push_back('{we: 1'b0, addr: a1, wdata: 8'h00});
            cpl_q.push_back('{ld: 1'b1, data: {hi, lo}, idx: idx});
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] v);
        ref_mem[a] = v;
        bus_mem[a] = v;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic w, input logic wd, input logic [15:0] a,
                         input logic [15:0] d, input logic [2:0] idx, output int acc);
        int n = 0;
        while (!bus_if.req_ready && n < 50) begin
            bus_if.req_valid = 1'($urandom_range(0, 1));
            bus_if.req_write = 1'($urandom_range(0, 1));
            bus_if.req_word  = 1'($urandom_range(0, 1));
            bus_if.req_addr  = 16'($urandom);
            bus_if.req_data  = 16'($urandom);
            bus_if.req_d_idx = 3'($urandom);
            @(negedge clk);
            n++;
        end
        acc = -1;
        if (!bus_if.req_ready) begin
            check("req_ready_timeout", 0, 1);
            bus_if.req_valid = 1'b0;
        end else begin
            bus_if.req_valid = 1'b1;
            bus_if.req_write = w;
            bus_if.req_word  = wd;
            bus_if.req_addr  = a;
            bus_if.req_data  = d;
            bus_if.req_d_idx = idx;
            acc = cyc;
            model(w, wd, a, d, idx);
            @(negedge clk);
            bus_if.req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((cpl_q.size() != 0 || !bus_if.req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 200), 1);
    endtask

    task automatic check_reset(input string p);
        check({p, "_req_ready"}, 32'(bus_if.req_ready), 1);
        check({p, "_busy"}, 32'(bus_if.busy), 0);
        check({p, "_bus_en"}, 32'(bus_if.bus_en), 0);
        check({p, "_bus_we"}, 32'(bus_if.bus_we), 0);
        check({p, "_bus_addr"}, 32'(bus_if.bus_addr), 0);
        check({p, "_bus_wdata"}, 32'(bus_if.bus_wdata), 0);
        check({p, "_ld_valid"}, 32'(bus_if.ld_valid), 0);
        check({p, "_st_done"}, 32'(bus_if.st_done), 0);
        check({p, "_ld_data"}, 32'(bus_if.ld_data), 0);
        check({p, "_ld_d_idx"}, 32'(bus_if.ld_d_idx), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int acc2;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i] = 8'($urandom);
            bus_mem[i] = ref_mem[i];
        end
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_word  = ACC_BYTE;
        bus_if.req_addr  = '0;
        bus_if.req_data  = '0;
        bus_if.req_d_idx = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset("por");

        poke(16'h1234, 8'hA7);
        issue(1'b0, ACC_BYTE, 16'h1234, 16'h5A5A, 3'd5, acc);
        wait_idle();
        check("byte_ld_latency", 32'(last_ld_cyc - acc), 2);
        check("byte_ld_value", 32'(bus_if.ld_data), 32'h00A7);
        check("byte_ld_idx", 32'(bus_if.ld_d_idx), 5);

        issue(1'b1, ACC_WORD, 16'h2000, 16'hBEEF, 3'd1, acc);
        wait_idle();
        check("word_st_latency", 32'(last_st_cyc - acc), 3);
        check("ld_data_hold", 32'(bus_if.ld_data), 32'h00A7);
        check("ld_idx_hold", 32'(bus_if.ld_d_idx), 5);
        check("word_st_lo_mem", 32'(bus_mem[16'h2000]), 32'hEF);
        check("word_st_hi_mem", 32'(bus_mem[16'h2001]), 32'hBE);

        poke(16'hFFFF, 8'h34);
        poke(16'h0000, 8'h12);
        wait_plan.push_back(2);
        wait_plan.push_back(1);
        issue(1'b0, ACC_WORD, 16'hFFFF, 16'h0000, 3'd3, acc);
        wait_idle();
        check("wrap_ld_latency", 32'(last_ld_cyc - acc), 6);
        check("wrap_ld_value", 32'(bus_if.ld_data), 32'h1234);

        issue(1'b1, ACC_WORD, 16'h3000, 16'hC3D2, 3'd0, acc);
        issue(1'b0, ACC_BYTE, 16'h3000, 16'h0000, 3'd2, acc2);
        wait_idle();
        check("b2b_accept_in_done_cycle", 32'(acc2), 32'(last_st_cyc));
        check("b2b_ld_latency", 32'(last_ld_cyc - acc2), 2);

        issue(1'b0, ACC_WORD, 16'h4000, 16'h1111, 3'd6, acc);
        @(negedge clk);
        check("hi_bus_en", 32'(bus_if.bus_en), 1);
        check("hi_bus_addr", 32'(bus_if.bus_addr), 32'h4001);
        check("hi_busy", 32'(bus_if.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_hi");
        cpl_q.delete();
        rst = 1'b0;

        rnd_waits = 1'b1;
        repeat (300) begin
            repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) @(negedge clk);
            a = $urandom_range(0, 3) == 0 ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                          : 16'($urandom_range(0, 15));
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                  16'($urandom), 3'($urandom), acc);
        end
        wait_idle();
        check("bus_q_drained", 32'(bus_q.size()), 0);
        check("cpl_q_drained", 32'(cpl_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
